// File: rtl/mem_pkg.sv
// Shared types and constants for the MAR/MDR memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_responder_if.sv
// Memory handshake bundle between the CPU initiator (master) and the responder (slave).
// The err signal exists only when MEM_RANGE_CHECK_EN is defined.
interface mem_responder_if #(
  parameter int DW = 16
);
  logic          mem_en;
  logic          mem_rw;
  logic [DW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          mfc;
  logic          busy;
`ifdef MEM_RANGE_CHECK_EN
  logic          err;

  modport master (output mem_en, mem_rw, addr, wdata,
                  input  rdata, mfc, busy, err);
  modport slave  (input  mem_en, mem_rw, addr, wdata,
                  output rdata, mfc, busy, err);
`else
  modport master (output mem_en, mem_rw, addr, wdata,
                  input  rdata, mfc, busy);
  modport slave  (input  mem_en, mem_rw, addr, wdata,
                  output rdata, mfc, busy);
`endif
endinterface

// File: rtl/mem_array.sv
// Single-port synchronous word storage with a registered read port.
// clear zeroes the read register instead of performing an access.
module mem_array #(
  parameter int DEPTH = 256,
  parameter int DW    = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          we,
  input  logic          clear,
  input  logic [AW-1:0] idx,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Clocked four-phase-handshake memory slave: accepts a request, waits WAIT_CYCLES, then raises mfc.
// Optional MEM_RANGE_CHECK_EN flags addresses >= DEPTH on err instead of wrapping them.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int DW          = 16
) (
  input  logic          clk,
  input  logic          reset,
  mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             rw_q;
  logic [DW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic             arr_en;
  logic             arr_we;
  logic             arr_clr;
  logic             out_of_range;

`ifdef MEM_RANGE_CHECK_EN
  assign out_of_range = (32'(addr_q) >= DEPTH);
  assign bus.err      = (state == ACK) && out_of_range;
`else
  logic unused_addr_hi;
  assign out_of_range   = 1'b0;
  assign unused_addr_hi = ^addr_q[DW-1:AW];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rw_q    <= MEM_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (state == IDLE && bus.mem_en) begin
        rw_q    <= bus.mem_rw;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
    end
  end

  // Every request passes through WAIT so a zero wait still gives a one-cycle mfc latency;
  // the array access fires on the edge that enters ACK.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    arr_en     = 1'b0;
    arr_we     = 1'b0;
    arr_clr    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mem_en) begin
          state_next = WAIT;
          cnt_next   = CNT_W'(WAIT_CYCLES);
        end
      end
      WAIT: begin
        if (!bus.mem_en) begin
          state_next = IDLE;
        end else if (cnt == '0) begin
          state_next = ACK;
          if (out_of_range) begin
            arr_clr = (rw_q == MEM_READ);
          end else begin
            arr_en = 1'b1;
            arr_we = (rw_q == MEM_WRITE);
          end
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      ACK: begin
        if (!bus.mem_en) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (reset) begin
      arr_en  = 1'b0;
      arr_we  = 1'b0;
      arr_clr = 1'b0;
    end
  end

  assign bus.mfc  = (state == ACK);
  assign bus.busy = (state != IDLE);

  mem_array #(
    .DEPTH(DEPTH),
    .DW   (DW),
    .AW   (AW)
  ) u_array (
    .clk  (clk),
    .reset(reset),
    .en   (arr_en),
    .we   (arr_we),
    .clear(arr_clr),
    .idx  (addr_q[AW-1:0]),
    .wdata(wdata_q),
    .rdata(bus.rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Drives identical transactions into a WAIT_CYCLES=0 and a WAIT_CYCLES=2 responder and
// checks each against a transaction-level model; define MEM_RANGE_CHECK_EN to cover err.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        rw;
  logic [15:0] a_drv;
  logic [15:0] d_drv;

  int n_checks = 0;
  int n_errors = 0;

  int          wc [2];
  logic [15:0] model [2][256];
  logic [15:0] exp_rd [2];

  logic [1:0]  mfc_o;
  logic [1:0]  busy_o;
  logic [15:0] rd_o [2];
`ifdef MEM_RANGE_CHECK_EN
  logic [1:0]  err_o;
`endif

  mem_responder_if #(.DW(16)) bus0 ();
  mem_responder_if #(.DW(16)) bus1 ();

  mem_responder #(.DEPTH(256), .WAIT_CYCLES(0), .DW(16)) dut0 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus0)
  );

  mem_responder #(.DEPTH(256), .WAIT_CYCLES(2), .DW(16)) dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1)
  );

  assign bus0.mem_en = en;
  assign bus0.mem_rw = rw;
  assign bus0.addr   = a_drv;
  assign bus0.wdata  = d_drv;
  assign bus1.mem_en = en;
  assign bus1.mem_rw = rw;
  assign bus1.addr   = a_drv;
  assign bus1.wdata  = d_drv;

  assign mfc_o  = {bus1.mfc, bus0.mfc};
  assign busy_o = {bus1.busy, bus0.busy};
  assign rd_o[0] = bus0.rdata;
  assign rd_o[1] = bus1.rdata;
`ifdef MEM_RANGE_CHECK_EN
  assign err_o  = {bus1.err, bus0.err};
`endif

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, got, want);
    end
  endtask

  function automatic logic isOor(input logic [15:0] a);
`ifdef MEM_RANGE_CHECK_EN
    return a >= 16'd256;
`else
    return a[15] & 1'b0;
`endif
  endfunction

  // One request held for 'hold' edges after the accepting edge, then released.
  // A responder with wait W completes only if hold >= W+1; mfc is then high for edges W+1..hold.
  task automatic applyStimulus(input logic t_rw, input logic [15:0] a, input logic [15:0] d,
                               input int hold);
    logic oor;
    logic committed;
    logic exp_mfc;
    oor = isOor(a);
    @(negedge clk);
    en = 1'b1; rw = t_rw; a_drv = a; d_drv = d;
    for (int k = 0; k <= hold + 1; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        committed = (hold >= wc[i] + 1);
        if (committed && k == wc[i] + 1) begin
          if (t_rw) begin
            if (!oor) model[i][a[7:0]] = d;
          end else begin
            exp_rd[i] = oor ? 16'h0000 : model[i][a[7:0]];
          end
        end
        exp_mfc = committed && (k >= wc[i] + 1) && (k <= hold);
        checkOutput($sformatf("w%0d mfc k%0d", wc[i], k), 16'(mfc_o[i]), 16'(exp_mfc));
        checkOutput($sformatf("w%0d busy k%0d", wc[i], k), 16'(busy_o[i]), 16'(k <= hold));
        checkOutput($sformatf("w%0d rdata k%0d", wc[i], k), rd_o[i], exp_rd[i]);
`ifdef MEM_RANGE_CHECK_EN
        checkOutput($sformatf("w%0d err k%0d", wc[i], k), 16'(err_o[i]), 16'(exp_mfc && oor));
`endif
      end
      if (k == 0) begin
        rw = 1'($urandom); a_drv = 16'($urandom); d_drv = 16'($urandom);
      end
      if (k == hold) en = 1'b0;
    end
  endtask

  // Write request interrupted by reset one edge after acceptance: nothing is committed.
  task automatic resetDuringWrite(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    en = 1'b1; rw = 1'b1; a_drv = a; d_drv = d;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_rd[i] = 16'h0000;
      checkOutput($sformatf("w%0d rst mfc", wc[i]), 16'(mfc_o[i]), 16'h0000);
      checkOutput($sformatf("w%0d rst busy", wc[i]), 16'(busy_o[i]), 16'h0000);
      checkOutput($sformatf("w%0d rst rdata", wc[i]), rd_o[i], 16'h0000);
    end
  endtask

  initial begin
    wc[0] = 0;
    wc[1] = 2;
    for (int i = 0; i < 2; i++) begin
      exp_rd[i] = 16'h0000;
      for (int j = 0; j < 256; j++) model[i][j] = 16'h0000;
    end
    reset = 1'b1; en = 1'b0; rw = 1'b0; a_drv = '0; d_drv = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("w%0d reset mfc", wc[i]), 16'(mfc_o[i]), 16'h0000);
      checkOutput($sformatf("w%0d reset busy", wc[i]), 16'(busy_o[i]), 16'h0000);
      checkOutput($sformatf("w%0d reset rdata", wc[i]), rd_o[i], 16'h0000);
    end

    for (int j = 0; j < 32; j++) applyStimulus(1'b1, 16'(j), 16'($urandom), 3);

    applyStimulus(1'b1, 16'h0005, 16'hBEEF, 3);
    applyStimulus(1'b0, 16'h0005, 16'h0000, 3);
    applyStimulus(1'b1, 16'h0006, 16'h1234, 3);
    applyStimulus(1'b1, 16'h0010, 16'hA5A5, 3);
    applyStimulus(1'b0, 16'h0010, 16'h0000, 3);

    applyStimulus(1'b1, 16'h0003, 16'h1111, 3);
    applyStimulus(1'b1, 16'h0003, 16'h7777, 1);
    applyStimulus(1'b1, 16'h0003, 16'h7777, 0);
    applyStimulus(1'b0, 16'h0003, 16'h0000, 3);

    applyStimulus(1'b1, 16'h0002, 16'h2222, 3);
    resetDuringWrite(16'h0002, 16'h5555);
    applyStimulus(1'b0, 16'h0002, 16'h0000, 3);

    applyStimulus(1'b1, 16'h0000, 16'hCAFE, 3);
    applyStimulus(1'b1, 16'h0100, 16'h00FF, 3);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 3);
    applyStimulus(1'b0, 16'h0100, 16'h0000, 3);

    for (int n = 0; n < 60; n++) begin
      logic [15:0] a;
      a = 16'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) a[15:8] = 8'($urandom_range(1, 255));
      applyStimulus(1'($urandom), a, 16'($urandom), $urandom_range(0, 5));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
